// File: rtl/me_pkg.sv
// Shared types and default widths for the motion-estimation frame scheduler.
package me_pkg;

  function automatic int me_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ME_NUM_BLOCKS      = 4;
  localparam int ME_DIST_W          = 8;
  localparam int ME_MV_W            = 4;
  localparam int ME_SETTLE_CYCLES   = 2;
  localparam int ME_TIMEOUT_CYCLES  = 4096;
  localparam int ME_IDX_W           = me_clog2_min1(ME_NUM_BLOCKS);

  typedef enum logic [2:0] {IDLE, SETTLE, RUN, EMIT, DONE} me_state_t;

  // Result record at the default widths.
  typedef struct packed {
    logic [ME_IDX_W-1:0]  blk;
    logic [ME_DIST_W-1:0] distance;
    logic [ME_MV_W-1:0]   mvx;
    logic [ME_MV_W-1:0]   mvy;
    logic                 timeout;
  } me_result_t;

endpackage

// File: rtl/me_watchdog.sv
// Loadable down-counter used for both the settle delay and the RUN watchdog.
module me_watchdog #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/me_block_scheduler.sv
// Frame sequencer: walks NUM_BLOCKS macroblocks through the ME core and
// returns one result per block on a valid/ready port.
module me_block_scheduler
  import me_pkg::*;
#(
  parameter int NUM_BLOCKS     = ME_NUM_BLOCKS,
  parameter int DIST_W         = ME_DIST_W,
  parameter int MV_W           = ME_MV_W,
  parameter int SETTLE_CYCLES  = ME_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = ME_TIMEOUT_CYCLES
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     frame_start,
  output logic                                     frame_busy,
  output logic                                     frame_done,
  output logic [me_clog2_min1(NUM_BLOCKS)-1:0]     bank_sel,
  output logic                                     me_start,
  input  logic                                     me_completed,
  input  logic [DIST_W-1:0]                        me_distance,
  input  logic [MV_W-1:0]                          me_mvx,
  input  logic [MV_W-1:0]                          me_mvy,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [me_clog2_min1(NUM_BLOCKS)-1:0]     res_blk,
  output logic [DIST_W-1:0]                        res_distance,
  output logic [MV_W-1:0]                          res_mvx,
  output logic [MV_W-1:0]                          res_mvy,
  output logic                                     res_timeout,
  output logic [DIST_W+me_clog2_min1(NUM_BLOCKS):0] frame_sum,
  output logic                                     err_sticky
);

  localparam int IDX_W   = me_clog2_min1(NUM_BLOCKS);
  localparam int SUM_W   = DIST_W + IDX_W + 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES - 1 : SETTLE_CYCLES - 1;
  localparam int CNT_W   = me_clog2_min1(CNT_MAX + 1);

  typedef struct packed {
    logic [IDX_W-1:0]  blk;
    logic [DIST_W-1:0] distance;
    logic [MV_W-1:0]   mvx;
    logic [MV_W-1:0]   mvy;
    logic              timeout;
  } res_t;

  me_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [SUM_W-1:0]  r_sum;
  res_t              r_res;
  logic              r_err;
  logic              r_completed;
  logic [DIST_W-1:0] r_core_dist;
  logic [MV_W-1:0]   r_core_mvx, r_core_mvy;

  logic              w_wd_clear, w_wd_load, w_wd_en, w_wd_expire;
  logic [CNT_W-1:0]  w_wd_load_val;
  logic              w_frame_go, w_cap_ok, w_cap_to, w_accept, w_last;

  assign w_last = (r_idx == IDX_W'(NUM_BLOCKS - 1));

  me_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_wd_clear),
    .i_load     (w_wd_load),
    .i_load_val (w_wd_load_val),
    .i_en       (w_wd_en),
    .o_expire   (w_wd_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_wd_clear    = 1'b0;
    w_wd_load     = 1'b0;
    w_wd_load_val = '0;
    w_wd_en       = 1'b0;
    w_frame_go    = 1'b0;
    w_cap_ok      = 1'b0;
    w_cap_to      = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: if (frame_start) begin
        w_frame_go    = 1'b1;
        w_wd_load     = 1'b1;
        w_wd_load_val = CNT_W'(SETTLE_CYCLES - 1);
        w_state_nxt   = SETTLE;
      end
      SETTLE: if (w_wd_expire) begin
        w_wd_load     = 1'b1;
        w_wd_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
        w_state_nxt   = RUN;
      end else begin
        w_wd_en = 1'b1;
      end
      // Completion is checked first so it wins over a same-cycle expiry.
      RUN: if (r_completed) begin
        w_cap_ok    = 1'b1;
        w_wd_clear  = 1'b1;
        w_state_nxt = EMIT;
      end else if (w_wd_expire) begin
        w_cap_to    = 1'b1;
        w_state_nxt = EMIT;
      end else begin
        w_wd_en = 1'b1;
      end
      EMIT: if (res_ready) begin
        w_accept = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_wd_load     = 1'b1;
          w_wd_load_val = CNT_W'(SETTLE_CYCLES - 1);
          w_state_nxt   = SETTLE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: pure data pipeline registers carry no reset; they are only consumed when r_completed qualifies them.
  always_ff @(posedge clock) begin
    r_core_dist <= me_distance;
    r_core_mvx  <= me_mvx;
    r_core_mvy  <= me_mvy;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_sum       <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_completed <= 1'b0;
    end else begin
      r_completed <= me_completed && (r_state == RUN);
      if (w_frame_go) begin
        r_idx <= '0;
        r_sum <= '0;
      end
      if (w_cap_ok) begin
        r_res.blk      <= r_idx;
        r_res.distance <= r_core_dist;
        r_res.mvx      <= r_core_mvx;
        r_res.mvy      <= r_core_mvy;
        r_res.timeout  <= 1'b0;
      end
      if (w_cap_to) begin
        r_res.blk      <= r_idx;
        r_res.distance <= '1;
        r_res.mvx      <= '0;
        r_res.mvy      <= '0;
        r_res.timeout  <= 1'b1;
        r_err          <= 1'b1;
      end
      if (w_accept) begin
        r_sum <= r_sum + SUM_W'(r_res.distance);
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign frame_busy   = (r_state == SETTLE) || (r_state == RUN) || (r_state == EMIT);
  assign frame_done   = (r_state == DONE);
  assign me_start     = (r_state == RUN);
  assign res_valid    = (r_state == EMIT);
  assign bank_sel     = r_idx;
  assign res_blk      = r_res.blk;
  assign res_distance = r_res.distance;
  assign res_mvx      = r_res.mvx;
  assign res_mvy      = r_res.mvy;
  assign res_timeout  = r_res.timeout;
  assign frame_sum    = r_sum;
  assign err_sticky   = r_err;

endmodule
